// File: rtl/ps2_tx_ctrl.sv
// PS/2 host-to-device transmitter with a command FIFO, start-bit hold,
// ACK sampling, transfer timeout and bounded automatic retry.
module ps2_tx_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 12000,
  parameter int unsigned SETUP_CYCLES   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code,
  inout  wire                           ps2_clk,
  inout  wire                           ps2_data
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  localparam logic [HW-1:0] HoldInit = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] SetupCnt = HW'(SETUP_CYCLES);
  localparam logic [TW-1:0] TmoInit  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);
  localparam logic [LW-1:0] DepthCnt = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StHold, StSend, StWait} state_e;

  // Frame as shifted out LSB first: start(0), d0..d7, odd parity, stop(1).
  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  state_e        state_q, state_d;
  logic [10:0]   shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          clk_low_q, clk_low_d;
  logic          data_low_q, data_low_d;
  logic [2:0]    clk_sync_q, data_sync_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] count_q, count_d;

  logic          push, pop;
  logic          clk_fall, line_clk, line_data;
  logic          fail;
  logic [1:0]    fail_code;
  logic          ack_edge;

  assign clk_fall  = (clk_sync_q[2:1] == 2'b10);
  assign line_clk  = clk_sync_q[2];
  assign line_data = data_sync_q[2];
  assign ack_edge  = clk_fall && (bitcnt_q == 4'd10);

  assign full     = (count_q == DepthCnt);
  assign level    = count_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

  assign ps2_clk  = clk_low_q  ? 1'b0 : 1'bz;
  assign ps2_data = data_low_q ? 1'b0 : 1'bz;

  // A full FIFO still accepts a write in the cycle it is popped.
  assign push    = wr_en && (!full || pop);
  assign count_d = count_q + LW'(push) - LW'(pop);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    bitcnt_d   = bitcnt_q;
    retry_d    = retry_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pop        = 1'b0;
    fail       = 1'b0;
    fail_code  = 2'b00;

    case (state_q)
      StIdle: begin
        if (tx_en && (count_q != '0) && line_clk && line_data) begin
          pop     = 1'b1;
          byte_d  = mem_q[rptr_q];
          shift_d = frame(mem_q[rptr_q]);
          retry_d = '0;
          hold_d  = HoldInit;
          state_d = StHold;
        end
      end
      StHold: begin
        if (hold_q == '0) begin
          bitcnt_d = '0;
          tmo_d    = TmoInit;
          state_d  = StSend;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      StSend: begin
        tmo_d = tmo_q - TW'(1);
        if (ack_edge && !line_data) begin
          done_d  = 1'b1;
          state_d = StWait;
        end else if (ack_edge || (tmo_q == '0)) begin
          fail      = 1'b1;
          fail_code = ack_edge ? 2'b01 : 2'b10;
        end else if (clk_fall) begin
          shift_d  = {1'b1, shift_q[10:1]};
          bitcnt_d = bitcnt_q + 4'd1;
        end
      end
      StWait: begin
        if (line_clk && line_data) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fail) begin
      if (retry_q < RetryMax) begin
        retry_d = retry_q + RW'(1);
        shift_d = frame(byte_q);
        hold_d  = HoldInit;
        state_d = StHold;
      end else begin
        err_d      = 1'b1;
        err_code_d = fail_code;
        state_d    = StWait;
      end
    end

    // Abort: drop the in-flight byte silently, keep queued bytes.
    if (!tx_en) begin
      state_d    = StIdle;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
    end

    clk_low_d  = (state_d == StHold);
    data_low_d = ((state_d == StHold) && (hold_d < SetupCnt)) ||
                 ((state_d == StSend) && !shift_d[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '1;
      byte_q      <= '0;
      hold_q      <= '0;
      tmo_q       <= '0;
      bitcnt_q    <= '0;
      retry_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      clk_low_q   <= 1'b0;
      data_low_q  <= 1'b0;
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      bitcnt_q    <= bitcnt_d;
      retry_q     <= retry_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      clk_low_q   <= clk_low_d;
      data_low_q  <= data_low_d;
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[1:0], ps2_data};
      count_q     <= count_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

endmodule
